// File: rtl/lead_delay_cal_pkg.sv
// lead_delay_cal_pkg
//   Shared types for the lead-delay calibration sequencer:
//   - state_e : sequencer states
//   - res_t   : per-channel result record {valid, timeout, latency}
//   - LAT_W   : latency field width of res_t (the top's CNT_W must equal it)
//   - flush_len() : FLUSH dwell length for a delay line of a given stage count
package lead_delay_cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        INJECT,
        WAIT,
        STORE,
        NEXT,
        DONE
    } state_e;

    localparam int LAT_W = 4;

    typedef struct packed {
        logic             valid;
        logic             timeout;
        logic [LAT_W-1:0] latency;
    } res_t;

    // Flushing must outlast the line's stages plus the input/output registers.
    function automatic int flush_len(input int stages);
        return stages + 2;
    endfunction

endpackage

// File: rtl/lead_delay_cal_rf.sv
// lead_delay_cal_rf
//   Result storage: DEPTH entries of res_t, one synchronous write port,
//   one asynchronous read port, synchronous clear (reset or clr_i).
//   Reads at raddr_i >= DEPTH return zero.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   clr_i             clear all entries to zero
//   we_i/waddr_i/wdata_i   write port
//   raddr_i/rdata_o        combinational read port
module lead_delay_cal_rf
    import lead_delay_cal_pkg::*;
#(
    parameter int DEPTH = 48,
    parameter int AW    = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  res_t          wdata_i,
    input  logic [AW-1:0] raddr_i,
    output res_t          rdata_o
);

    res_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i && int'(waddr_i) < DEPTH) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (int'(raddr_i) < DEPTH) rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/lead_delay_cal.sv
// lead_delay_cal
//   Sweeps a bank of controlled delay lines channel by channel: flush the
//   line, inject a single-cycle pulse, count cycles until it emerges (or
//   time out), and store {valid, timeout, latency} per channel. In IDLE the
//   live leads/retriggers pass straight through to the delay lines.
// Optional feature: define LEAD_DELAY_CAL_ABORT_EN to add the 'abort' input,
//   which ends a sweep early (results stored so far are kept).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, ch_mask      sweep request and channel selection (sampled at start)
//   lead_in, retrig_in  live inputs forwarded while idle
//   dly_in, retrig      drive the delay lines
//   dly_out             delay line outputs
//   busy, done          sweep in progress / one-cycle end pulse
//   rd_addr, rd_data    asynchronous result read
//   fail_cnt            timed-out channels in the last sweep (saturating)
module lead_delay_cal
    import lead_delay_cal_pkg::*;
#(
    parameter int WIDTH   = 48,
    parameter int STAGES  = 5,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ch_mask,
    input  logic [WIDTH-1:0] lead_in,
    input  logic [WIDTH-1:0] retrig_in,
    output logic [WIDTH-1:0] dly_in,
    output logic [WIDTH-1:0] retrig,
    input  logic [WIDTH-1:0] dly_out,
    output logic             busy,
    output logic             done,
    input  logic [5:0]       rd_addr,
    output logic [CNT_W+1:0] rd_data,
    output logic [5:0]       fail_cnt
`ifdef LEAD_DELAY_CAL_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int FLUSH_LEN = flush_len(STAGES);
    localparam int FC_W      = $clog2(FLUSH_LEN + 1);

    state_e           state_q;
    logic [WIDTH-1:0] mask_q;
    logic [5:0]       ch_q;
    logic [FC_W-1:0]  fc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] lat_q;
    logic             tmo_q;
    logic [5:0]       fail_q;
    logic             done_q;
    logic             abort_w;
    logic             clr_w;
    res_t             wr_rec;
    res_t             rd_rec;

`ifdef LEAD_DELAY_CAL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign clr_w = (state_q == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ch_q    <= '0;
            fc_q    <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            tmo_q   <= 1'b0;
            fail_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // DONE is already on its way out, so abort there must not re-enter it.
            if (abort_w && state_q != IDLE && state_q != DONE) begin
                state_q <= DONE;
            end else begin
                unique case (state_q)
                    IDLE: if (start) begin
                        mask_q  <= ch_mask;
                        ch_q    <= '0;
                        fc_q    <= '0;
                        fail_q  <= '0;
                        state_q <= FLUSH;
                    end
                    FLUSH: begin
                        if (fc_q == FC_W'(FLUSH_LEN - 1)) begin
                            fc_q    <= '0;
                            state_q <= mask_q[ch_q] ? INJECT : NEXT;
                        end else begin
                            fc_q <= fc_q + 1'b1;
                        end
                    end
                    INJECT: begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                    WAIT: begin
                        cnt_q <= cnt_q + 1'b1;
                        // A hit on the last allowed cycle wins over the timeout.
                        if (dly_out[ch_q]) begin
                            tmo_q   <= 1'b0;
                            lat_q   <= cnt_q + 1'b1;
                            state_q <= STORE;
                        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                            tmo_q   <= 1'b1;
                            lat_q   <= CNT_W'(TIMEOUT);
                            fail_q  <= (fail_q == 6'd63) ? fail_q : fail_q + 1'b1;
                            state_q <= STORE;
                        end
                    end
                    STORE: state_q <= NEXT;
                    NEXT: begin
                        if (ch_q == 6'(WIDTH - 1)) begin
                            state_q <= DONE;
                        end else begin
                            ch_q    <= ch_q + 1'b1;
                            state_q <= FLUSH;
                        end
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Live passthrough only in IDLE; otherwise the sequencer owns the lines.
    always_comb begin
        dly_in = '0;
        retrig = '0;
        if (state_q == IDLE) begin
            dly_in = lead_in;
            retrig = retrig_in;
        end else if (state_q == INJECT) begin
            dly_in[ch_q] = 1'b1;
        end
    end

    always_comb begin
        wr_rec         = '0;
        wr_rec.valid   = 1'b1;
        wr_rec.timeout = tmo_q;
        wr_rec.latency = lat_q;
    end

    lead_delay_cal_rf #(
        .DEPTH (WIDTH),
        .AW    (6)
    ) u_rf (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (clr_w),
        .we_i    (state_q == STORE),
        .waddr_i (ch_q),
        .wdata_i (wr_rec),
        .raddr_i (rd_addr),
        .rdata_o (rd_rec)
    );

    assign rd_data  = rd_rec;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_lead_delay_cal.sv
module tb_lead_delay_cal;

    localparam int WIDTH   = 48;
    localparam int STAGES  = 5;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;
    localparam int LIMIT   = 2000;
    localparam int HDEPTH  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] ch_mask, lead_in, retrig_in;
    logic [WIDTH-1:0] dly_in, retrig, dly_out;
    logic             busy, done;
    logic [5:0]       rd_addr;
    logic [CNT_W+1:0] rd_data;
    logic [5:0]       fail_cnt;
`ifdef LEAD_DELAY_CAL_ABORT_EN
    logic             abort;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Delay-line model: each channel echoes its own dly_in bit after dly_ch[c] cycles.
    logic [WIDTH-1:0] hist [HDEPTH];
    int               dly_ch [WIDTH];
    logic [WIDTH-1:0] stuck;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < HDEPTH; k++) hist[k] <= '0;
        end else begin
            for (int k = HDEPTH - 1; k > 0; k--) hist[k] <= hist[k-1];
            hist[0] <= dly_in;
        end
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_dl
        assign dly_out[c] = hist[dly_ch[c] - 1][c] & ~stuck[c];
    end

    always #5 clk = ~clk;

    lead_delay_cal #(
        .WIDTH(WIDTH), .STAGES(STAGES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask),
        .lead_in(lead_in), .retrig_in(retrig_in), .dly_in(dly_in),
        .retrig(retrig), .dly_out(dly_out), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .fail_cnt(fail_cnt)
`ifdef LEAD_DELAY_CAL_ABORT_EN
        , .abort(abort)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [WIDTH-1:0] rand_vec();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[WIDTH-1:0];
    endfunction

    function automatic bit times_out(input int c);
        return stuck[c] || dly_ch[c] > TIMEOUT;
    endfunction

    function automatic logic [CNT_W+1:0] exp_res(input int c, input logic [WIDTH-1:0] m);
        if (c >= WIDTH) return '0;
        if (!m[c]) return '0;
        if (times_out(c)) return {1'b1, 1'b1, CNT_W'(TIMEOUT)};
        return {1'b1, 1'b0, CNT_W'(dly_ch[c])};
    endfunction

    // Inclusive count from the start cycle to the done cycle.
    function automatic int exp_cycles(input logic [WIDTH-1:0] m);
        int n;
        n = WIDTH * (STAGES + 3) + 3;
        for (int c = 0; c < WIDTH; c++)
            if (m[c]) n += (times_out(c) ? TIMEOUT : dly_ch[c]) + 2;
        return n;
    endfunction

    function automatic int exp_fails(input logic [WIDTH-1:0] m);
        int n;
        n = 0;
        for (int c = 0; c < WIDTH; c++) if (m[c] && times_out(c)) n++;
        return (n > 63) ? 63 : n;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_cycles(input int n);
        lead_in = '0; retrig_in = '0; start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Runs one sweep; reports inclusive start->done length, done pulse count
    // and the number of busy cycles where the line outputs were not sequencer-only.
    task automatic run_sweep(input logic [WIDTH-1:0] m, output int cyc,
                             output int ndone, output int bad);
        int i;
        cyc = 0; ndone = 0; bad = 0;
        @(negedge clk);
        start = 1'b1; ch_mask = m;
        @(negedge clk);
        start = 1'b0; ch_mask = rand_vec();
        i = 1;
        while (i < LIMIT) begin
            if (done) begin
                ndone++;
                if (cyc == 0) cyc = i + 1;
            end
            if (busy) begin
                if (!$onehot0(dly_in) || retrig != '0) bad++;
                lead_in   = rand_vec();
                retrig_in = rand_vec();
                start     = ($urandom_range(0, 7) == 0);
            end else begin
                lead_in = '0; retrig_in = '0; start = 1'b0;
            end
            if (cyc != 0 && i >= cyc + 4) break;
            @(negedge clk);
            i++;
        end
        lead_in = '0; retrig_in = '0; start = 1'b0;
    endtask

    task automatic set_delays(input int d);
        for (int c = 0; c < WIDTH; c++) dly_ch[c] = d;
        stuck = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_cycles(4);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || fail_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_outputs busy=%b done=%b fail_cnt=%0d, required 0 0 0", busy, done, fail_cnt);
        end
        for (int a = 0; a < 64; a += 9) begin
            rd_addr = 6'(a); #1;
            n_tests++;
            if (rd_data !== '0) begin
                n_fail++;
                $display("FAIL reset_result[%0d] got %h, required 0", a, rd_data);
            end
        end
    endtask

    task automatic test_passthrough();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            lead_in = rand_vec(); retrig_in = rand_vec();
            #1;
            n_tests++;
            if (dly_in !== lead_in || retrig !== retrig_in || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL passthrough dly_in=%h retrig=%h busy=%b, required %h %h 0",
                         dly_in, retrig, busy, lead_in, retrig_in);
            end
        end
        idle_cycles(HDEPTH);
    endtask

    // Full sweep with checks of done count, length, fail_cnt, busy outputs and results.
    task automatic test_sweep(input string name, input logic [WIDTH-1:0] m);
        int cyc, nd, bad;
        run_sweep(m, cyc, nd, bad);
        n_tests++;
        if (nd !== 1) begin
            n_fail++; $display("FAIL %s_done_pulses got %0d, required 1", name, nd);
        end
        n_tests++;
        if (cyc !== exp_cycles(m)) begin
            n_fail++; $display("FAIL %s_cycles got %0d, required %0d", name, cyc, exp_cycles(m));
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL %s_busy_outputs got %0d bad cycles, required 0", name, bad);
        end
        n_tests++;
        if (fail_cnt !== 6'(exp_fails(m))) begin
            n_fail++; $display("FAIL %s_fail_cnt got %0d, required %0d", name, fail_cnt, exp_fails(m));
        end
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a); #1;
            n_tests++;
            if (rd_data !== exp_res(a, m)) begin
                n_fail++;
                $display("FAIL %s_result[%0d] got %h, required %h", name, a, rd_data, exp_res(a, m));
            end
        end
        idle_cycles(HDEPTH);
    endtask

    task automatic test_lat5_all();
        set_delays(5);
        test_sweep("lat5_all", '1);
    endtask

    task automatic test_stuck_ch7();
        set_delays(5);
        stuck[7] = 1'b1;
        test_sweep("stuck7", '1);
        stuck = '0;
    endtask

    task automatic test_mask5();
        logic [WIDTH-1:0] m;
        set_delays(5);
        m = '0; m[0] = 1'b1; m[2] = 1'b1;
        test_sweep("mask5", m);
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < WIDTH; c++) dly_ch[c] = int'($urandom_range(1, TIMEOUT + 2));
            stuck = rand_vec() & rand_vec() & rand_vec();
            test_sweep("random", rand_vec());
        end
        stuck = '0;
    endtask

    task automatic test_rst_mid();
        int i;
        bit seen;
        logic [WIDTH-1:0] pv;
        set_delays(5);
        @(negedge clk);
        start = 1'b1; ch_mask = '1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (i = 0; i < LIMIT && !seen; i++) begin
            if (dly_in[20] === 1'b1) seen = 1;
            else @(negedge clk);
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL rst_mid_inject20 not seen within %0d cycles, required seen", LIMIT);
        end
        // Mid-sweep read of an already measured channel.
        rd_addr = 6'd19; #1;
        n_tests++;
        if (rd_data !== exp_res(19, '1)) begin
            n_fail++; $display("FAIL rst_mid_read19 got %h, required %h", rd_data, exp_res(19, '1));
        end
        @(negedge clk);          // channel 20 now in WAIT
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pv = rand_vec(); lead_in = pv; retrig_in = ~pv;
        #1;
        n_tests++;
        if (busy !== 1'b0 || dly_in !== pv || retrig !== ~pv) begin
            n_fail++;
            $display("FAIL rst_mid_passthrough busy=%b dly_in=%h retrig=%h, required 0 %h %h",
                     busy, dly_in, retrig, pv, ~pv);
        end
        i = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) i++;
        end
        lead_in = '0; retrig_in = '0;
        n_tests++;
        if (i !== 0 || fail_cnt !== 6'd0) begin
            n_fail++; $display("FAIL rst_mid_no_done done_pulses=%0d fail_cnt=%0d, required 0 0", i, fail_cnt);
        end
        for (int a = 0; a < WIDTH; a++) begin
            rd_addr = 6'(a); #1;
            n_tests++;
            if (rd_data !== '0) begin
                n_fail++; $display("FAIL rst_mid_result[%0d] got %h, required 0", a, rd_data);
            end
        end
        idle_cycles(HDEPTH);
    endtask

`ifdef LEAD_DELAY_CAL_ABORT_EN
    task automatic test_abort();
        bit seen;
        logic [CNT_W+1:0] e;
        set_delays(5);
        @(negedge clk);
        start = 1'b1; ch_mask = '1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < LIMIT && !seen; i++) begin
            if (dly_in[10] === 1'b1) seen = 1;
            else @(negedge clk);
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL abort_inject10 not seen, required seen");
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_done done=%b busy=%b, required 1 0", done, busy);
        end
        for (int a = 0; a < WIDTH; a++) begin
            e = (a < 10) ? exp_res(a, '1) : '0;
            rd_addr = 6'(a); #1;
            n_tests++;
            if (rd_data !== e) begin
                n_fail++; $display("FAIL abort_result[%0d] got %h, required %h", a, rd_data, e);
            end
        end
        idle_cycles(HDEPTH);
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; ch_mask = '0; lead_in = '0; retrig_in = '0;
        rd_addr = '0; stuck = '0;
`ifdef LEAD_DELAY_CAL_ABORT_EN
        abort = 1'b0;
`endif
        set_delays(5);
        test_reset();
        test_passthrough();
        test_lat5_all();
        test_stuck_ch7();
        test_mask5();
        test_random();
        test_rst_mid();
        test_passthrough();
`ifdef LEAD_DELAY_CAL_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
